// File: rtl/fp_mul_param.sv
`default_nettype none
// ============================================================================
// fp_mul_param : multi-cycle IEEE-754 style multiplier, parameterised widths
// Revision     : 1.0
// ============================================================================
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXP_W+MAN_W:0] input_a,
  input  logic [EXP_W+MAN_W:0] input_b,
  input  logic [1:0]           round_mode,
  input  logic                 input_stb,
  output logic                 input_ack,
  output logic [EXP_W+MAN_W:0] output_z,
  output logic [3:0]           output_flags,
  output logic                 output_z_stb,
  input  logic                 output_z_ack
);

  localparam int c_w  = 1 + EXP_W + MAN_W;
  localparam int c_mw = MAN_W + 1;
  localparam int c_pw = 2 * c_mw;
  localparam int c_ew = EXP_W + 2;

  localparam logic signed [c_ew-1:0] c_one    = {{(c_ew-1){1'b0}}, 1'b1};
  localparam logic signed [c_ew-1:0] c_bias   = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [c_ew-1:0] c_emin   = c_one - c_bias;
  localparam logic [EXP_W-1:0]       c_bias_e = {1'b0, {(EXP_W-1){1'b1}}};

  localparam logic [3:0] c_GET     = 4'd0;
  localparam logic [3:0] c_UNPACK  = 4'd1;
  localparam logic [3:0] c_SPECIAL = 4'd2;
  localparam logic [3:0] c_NORM_A  = 4'd3;
  localparam logic [3:0] c_NORM_B  = 4'd4;
  localparam logic [3:0] c_MULT_0  = 4'd5;
  localparam logic [3:0] c_MULT_1  = 4'd6;
  localparam logic [3:0] c_NORM_1  = 4'd7;
  localparam logic [3:0] c_NORM_2  = 4'd8;
  localparam logic [3:0] c_ROUND   = 4'd9;
  localparam logic [3:0] c_PACK    = 4'd10;
  localparam logic [3:0] c_PUT_Z   = 4'd11;

  logic [3:0]             r_state;
  logic [c_w-1:0]         r_a, r_b;
  logic [1:0]             r_rm;
  logic signed [c_ew-1:0] r_a_e, r_b_e, r_z_e;
  logic [c_mw-1:0]        r_a_m, r_b_m, r_z_m;
  logic [c_pw-1:0]        r_prod;
  logic                   r_z_s, r_guard, r_round, r_sticky, r_inexact;

  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic             w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [c_w-1:0]   w_qnan;

  assign w_a_exp  = r_a[MAN_W +: EXP_W];
  assign w_b_exp  = r_b[MAN_W +: EXP_W];
  assign w_a_frac = r_a[MAN_W-1:0];
  assign w_b_frac = r_b[MAN_W-1:0];
  assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
  assign w_b_nan  = (&w_b_exp) & (|w_b_frac);
  assign w_a_snan = w_a_nan & ~w_a_frac[MAN_W-1];
  assign w_b_snan = w_b_nan & ~w_b_frac[MAN_W-1];
  assign w_a_inf  = (&w_a_exp) & ~(|w_a_frac);
  assign w_b_inf  = (&w_b_exp) & ~(|w_b_frac);
  assign w_a_zero = ~(|w_a_exp) & ~(|w_a_frac);
  assign w_b_zero = ~(|w_b_exp) & ~(|w_b_frac);
  assign w_qnan   = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Rounding decision and incremented mantissa (extra MSB catches carry-out)
  logic            w_grs, w_inc;
  logic [c_mw:0]   w_m_inc;

  always_comb begin
    w_grs = r_guard | r_round | r_sticky;
    case (r_rm)
      2'd0:    w_inc = r_guard & (r_round | r_sticky | r_z_m[0]);
      2'd1:    w_inc = 1'b0;
      2'd2:    w_inc = ~r_z_s & w_grs;
      default: w_inc = r_z_s & w_grs;
    endcase
    w_m_inc = {1'b0, r_z_m} + {{c_mw{1'b0}}, w_inc};
  end

  // Final packing; an unnormalised mantissa only survives at the minimum exponent
  logic             w_ovf;
  logic [EXP_W-1:0] w_exp_field;
  logic [c_w-1:0]   w_inf_z, w_max_z, w_pack_z;
  logic [3:0]       w_pack_flags;

  always_comb begin
    w_ovf       = (r_z_e > c_bias);
    w_exp_field = r_z_m[MAN_W] ? (r_z_e[EXP_W-1:0] + c_bias_e) : {EXP_W{1'b0}};
    w_inf_z     = {r_z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    w_max_z     = {r_z_s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    w_pack_z    = {r_z_s, w_exp_field, r_z_m[MAN_W-1:0]};
    if (w_ovf) begin
      case (r_rm)
        2'd0:    w_pack_z = w_inf_z;
        2'd1:    w_pack_z = w_max_z;
        2'd2:    w_pack_z = r_z_s ? w_max_z : w_inf_z;
        default: w_pack_z = r_z_s ? w_inf_z : w_max_z;
      endcase
    end
    w_pack_flags = {1'b0, w_ovf, ~w_ovf & ~(|w_exp_field) & r_inexact, r_inexact | w_ovf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_GET;
      input_ack    <= 1'b0;
      output_z     <= '0;
      output_flags <= '0;
      output_z_stb <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_rm         <= '0;
      r_a_e        <= '0;
      r_b_e        <= '0;
      r_z_e        <= '0;
      r_a_m        <= '0;
      r_b_m        <= '0;
      r_z_m        <= '0;
      r_prod       <= '0;
      r_z_s        <= 1'b0;
      r_guard      <= 1'b0;
      r_round      <= 1'b0;
      r_sticky     <= 1'b0;
      r_inexact    <= 1'b0;
    end else begin
      case (r_state)
        c_GET: begin
          if (input_stb && input_ack) begin
            r_a       <= input_a;
            r_b       <= input_b;
            r_rm      <= round_mode;
            input_ack <= 1'b0;
            r_state   <= c_UNPACK;
          end else begin
            input_ack <= 1'b1;
          end
        end
        c_UNPACK: begin
          r_a_e   <= (|w_a_exp) ? ($signed({2'b00, w_a_exp}) - c_bias) : c_emin;
          r_b_e   <= (|w_b_exp) ? ($signed({2'b00, w_b_exp}) - c_bias) : c_emin;
          r_a_m   <= {|w_a_exp, w_a_frac};
          r_b_m   <= {|w_b_exp, w_b_frac};
          r_z_s   <= r_a[c_w-1] ^ r_b[c_w-1];
          r_state <= c_SPECIAL;
        end
        c_SPECIAL: begin
          if (w_a_nan || w_b_nan) begin
            output_z     <= w_qnan;
            output_flags <= {w_a_snan | w_b_snan, 3'b000};
            output_z_stb <= 1'b1;
            r_state      <= c_PUT_Z;
          end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            output_z     <= w_qnan;
            output_flags <= 4'b1000;
            output_z_stb <= 1'b1;
            r_state      <= c_PUT_Z;
          end else if (w_a_inf || w_b_inf) begin
            output_z     <= {r_z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            output_flags <= 4'b0000;
            output_z_stb <= 1'b1;
            r_state      <= c_PUT_Z;
          end else if (w_a_zero || w_b_zero) begin
            output_z     <= {r_z_s, {(c_w-1){1'b0}}};
            output_flags <= 4'b0000;
            output_z_stb <= 1'b1;
            r_state      <= c_PUT_Z;
          end else begin
            r_state <= c_NORM_A;
          end
        end
        c_NORM_A: begin
          if (!r_a_m[MAN_W]) begin
            r_a_m <= {r_a_m[MAN_W-1:0], 1'b0};
            r_a_e <= r_a_e - c_one;
          end else begin
            r_state <= c_NORM_B;
          end
        end
        c_NORM_B: begin
          if (!r_b_m[MAN_W]) begin
            r_b_m <= {r_b_m[MAN_W-1:0], 1'b0};
            r_b_e <= r_b_e - c_one;
          end else begin
            r_state <= c_MULT_0;
          end
        end
        c_MULT_0: begin
          r_prod  <= {{c_mw{1'b0}}, r_a_m} * {{c_mw{1'b0}}, r_b_m};
          r_z_e   <= r_a_e + r_b_e + c_one;
          r_state <= c_MULT_1;
        end
        c_MULT_1: begin
          r_z_m    <= r_prod[c_pw-1 -: c_mw];
          r_guard  <= r_prod[MAN_W];
          r_round  <= r_prod[MAN_W-1];
          r_sticky <= |r_prod[MAN_W-2:0];
          r_state  <= c_NORM_1;
        end
        c_NORM_1: begin
          // Both mantissas are normalised here, so the product needs at most one
          // left shift; it is done in the single visit to this state.
          if (!r_z_m[MAN_W]) begin
            r_z_m   <= {r_z_m[MAN_W-1:0], r_guard};
            r_guard <= r_round;
            r_round <= 1'b0;
            r_z_e   <= r_z_e - c_one;
          end
          r_state <= c_NORM_2;
        end
        c_NORM_2: begin
          if (r_z_e < c_emin) begin
            r_z_m    <= {1'b0, r_z_m[MAN_W:1]};
            r_guard  <= r_z_m[0];
            r_round  <= r_guard;
            r_sticky <= r_sticky | r_round;
            r_z_e    <= r_z_e + c_one;
          end else begin
            r_state <= c_ROUND;
          end
        end
        c_ROUND: begin
          r_inexact <= w_grs;
          if (w_m_inc[c_mw]) begin
            r_z_m <= {1'b1, {MAN_W{1'b0}}};
            r_z_e <= r_z_e + c_one;
          end else begin
            r_z_m <= w_m_inc[c_mw-1:0];
          end
          r_state <= c_PACK;
        end
        c_PACK: begin
          output_z     <= w_pack_z;
          output_flags <= w_pack_flags;
          output_z_stb <= 1'b1;
          r_state      <= c_PUT_Z;
        end
        c_PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            input_ack    <= 1'b1;
            r_state      <= c_GET;
          end
        end
        default: r_state <= c_GET;
      endcase
    end
  end

endmodule
`default_nettype wire
